// File: rtl/timer_sched_ctrl.sv
// Programmable one-shot / periodic timer: prescaler, terminal-count compare and
// up/down counter sequencing, with a valid/ready terminal-event output.
module timer_sched_ctrl #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [WIDTH-1:0]       cfg_limit_i,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
  input  logic                   cfg_periodic_i,
  input  logic                   cfg_down_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       count_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic                   evt_miss_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;

  localparam logic [WIDTH-1:0]       CNT_ONE   = WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       limit_q, count_q, start_val;
  logic [PRESC_WIDTH-1:0] presc_val_q, presc_q;
  logic                   periodic_q, down_q;
  logic                   busy_q, evt_valid_q, evt_miss_q;
  logic                   cfg_fire, tick, at_term;
  logic                   load_cfg, load_start, halt_run, term_tick, step_cnt, reload_cnt;

  assign cfg_ready_o = (state_q != RUN);
  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign tick        = (state_q == RUN) && (presc_q == presc_val_q);
  assign at_term     = down_q ? (count_q == '0) : (count_q == limit_q);
  assign start_val   = down_q ? limit_q : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // stop has priority over any same-cycle tick, so a stopped run never steps or fires
  always_comb begin
    state_d    = state_q;
    load_cfg   = 1'b0;
    load_start = 1'b0;
    halt_run   = 1'b0;
    term_tick  = 1'b0;
    step_cnt   = 1'b0;
    reload_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          load_cfg = 1'b1;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (cfg_fire) begin
          load_cfg = 1'b1;
        end else if (start_i && !stop_i) begin
          load_start = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          halt_run = 1'b1;
          state_d  = ARMED;
        end else if (tick) begin
          if (at_term) begin
            term_tick = 1'b1;
            if (periodic_q) reload_cnt = 1'b1;
            else            state_d    = ARMED;
          end else begin
            step_cnt = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      limit_q     <= '0;
      presc_val_q <= '0;
      periodic_q  <= 1'b0;
      down_q      <= 1'b0;
      count_q     <= '0;
      presc_q     <= '0;
      busy_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_miss_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);

      if (load_cfg) begin
        limit_q     <= cfg_limit_i;
        presc_val_q <= cfg_presc_i;
        periodic_q  <= cfg_periodic_i;
        down_q      <= cfg_down_i;
        count_q     <= cfg_down_i ? cfg_limit_i : '0;
      end else if (load_start || reload_cnt) begin
        count_q <= start_val;
      end else if (step_cnt) begin
        count_q <= down_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
      end

      if (load_cfg || load_start || halt_run || tick) presc_q <= '0;
      else if (state_q == RUN)                        presc_q <= presc_q + PRESC_ONE;

      // a fresh terminal event overrides a same-cycle acceptance of the old one
      if (term_tick)                        evt_valid_q <= 1'b1;
      else if (evt_valid_q && evt_ready_i)  evt_valid_q <= 1'b0;

      if (load_cfg)                                         evt_miss_q <= 1'b0;
      else if (term_tick && evt_valid_q && !evt_ready_i)    evt_miss_q <= 1'b1;
    end
  end

  assign busy_o      = busy_q;
  assign count_o     = count_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_miss_o  = evt_miss_q;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Bench for timer_sched_ctrl: vector table, directed corner sequences and
// randomized traffic checked against an elapsed-time reference model.
module tb_timer_sched_ctrl;

  logic        clk;
  logic        rst, cfg_valid, cfg_periodic, cfg_down, start, stop, evt_ready;
  logic [15:0] cfg_limit;
  logic [7:0]  cfg_presc;
  logic        cfg_ready, busy, evt_valid, evt_miss;
  logic [15:0] count;

  logic        w_rst, w_cfg_valid, w_periodic, w_down, w_start, w_stop, w_evt_ready;
  logic [3:0]  w_limit;
  logic [7:0]  w_presc;
  logic        w_cfg_ready, w_busy, w_evt_valid, w_evt_miss;
  logic [3:0]  w_count;

  int n_checks = 0;
  int n_errors = 0;

  timer_sched_ctrl #(.WIDTH(16), .PRESC_WIDTH(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_limit_i(cfg_limit), .cfg_presc_i(cfg_presc), .cfg_periodic_i(cfg_periodic),
    .cfg_down_i(cfg_down), .start_i(start), .stop_i(stop), .busy_o(busy),
    .count_o(count), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_miss_o(evt_miss)
  );

  timer_sched_ctrl #(.WIDTH(4), .PRESC_WIDTH(8)) u_w4 (
    .clk_i(clk), .rst_i(w_rst), .cfg_valid_i(w_cfg_valid), .cfg_ready_o(w_cfg_ready),
    .cfg_limit_i(w_limit), .cfg_presc_i(w_presc), .cfg_periodic_i(w_periodic),
    .cfg_down_i(w_down), .start_i(w_start), .stop_i(w_stop), .busy_o(w_busy),
    .count_o(w_count), .evt_valid_o(w_evt_valid), .evt_ready_i(w_evt_ready), .evt_miss_o(w_evt_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the run is described by cycles elapsed since start;
  // count and terminal ticks are derived arithmetically from that.
  int m_state = 0;  // 0 idle, 1 armed, 2 run
  int m_L = 0, m_P = 0, m_phase = 0, m_count = 0;
  bit m_per = 0, m_down = 0, m_evt = 0, m_miss = 0;
  int m_cur, m_len;
  bit m_term, m_evt_old;

  function automatic int m_cnt_now();
    int q;
    if (m_state == 2) begin
      q = m_phase / (m_P + 1);
      return m_down ? (m_L - q) : q;
    end
    return m_count;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_L = 0; m_P = 0; m_phase = 0; m_count = 0;
      m_per = 0; m_down = 0; m_evt = 0; m_miss = 0;
    end else begin
      m_cur     = m_cnt_now();
      m_evt_old = m_evt;
      m_term    = 0;
      if (m_state == 2) begin
        m_len = (m_L + 1) * (m_P + 1);
        if (stop) begin
          m_count = m_cur;
          m_state = 1;
        end else if (m_phase == m_len - 1) begin
          m_term = 1;
          if (m_per) m_phase = 0;
          else begin
            m_count = m_cur;
            m_state = 1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end else if (cfg_valid) begin
        m_L     = int'(cfg_limit);
        m_P     = int'(cfg_presc);
        m_per   = cfg_periodic;
        m_down  = cfg_down;
        m_count = cfg_down ? m_L : 0;
        m_miss  = 0;
        m_state = 1;
      end else if (m_state == 1 && start && !stop) begin
        m_state = 2;
        m_phase = 0;
      end
      if (m_term) begin
        if (m_evt_old && !evt_ready) m_miss = 1;
        m_evt = 1;
      end else if (m_evt_old && evt_ready) begin
        m_evt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    int          c;
    logic [19:0] e_vec, a_vec;
    c     = m_cnt_now();
    e_vec = {c[15:0], m_state == 2, m_evt, m_miss, m_state != 2};
    a_vec = {count, busy, evt_valid, evt_miss, cfg_ready};
    chk($sformatf("model t=%0t {cnt,busy,evt,miss,rdy}", $time), 32'(a_vec), 32'(e_vec));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic do_cfg(input logic [15:0] l, input logic [7:0] p, input logic per, input logic dn);
    cfg_valid = 1'b1; cfg_limit = l; cfg_presc = p; cfg_periodic = per; cfg_down = dn;
    tick();
    cfg_valid = 1'b0;
  endtask

  typedef struct packed {
    logic        rst, cv;
    logic [15:0] l;
    logic [7:0]  p;
    logic        per, dn, st, sp, rdy;
    logic [15:0] e_cnt;
    logic        e_busy, e_evt, e_miss, e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic cv, input logic [15:0] l, input logic [7:0] p,
                     input logic per, input logic dn, input logic st, input logic sp, input logic rdy,
                     input logic [15:0] ec, input logic eb, input logic ee, input logic em, input logic er);
    vec_t v;
    v = '{rst: r, cv: cv, l: l, p: p, per: per, dn: dn, st: st, sp: sp, rdy: rdy,
          e_cnt: ec, e_busy: eb, e_evt: ee, e_miss: em, e_rdy: er};
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] seq [6];
    seq[0] = 16'd2; seq[1] = 16'd2; seq[2] = 16'd1; seq[3] = 16'd1; seq[4] = 16'd0; seq[5] = 16'd0;

    rst = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_presc = '0; cfg_periodic = 1'b0;
    cfg_down = 1'b0; start = 1'b0; stop = 1'b0; evt_ready = 1'b0;
    w_rst = 1'b1; w_cfg_valid = 1'b0; w_limit = '0; w_presc = '0; w_periodic = 1'b0;
    w_down = 1'b0; w_start = 1'b0; w_stop = 1'b0; w_evt_ready = 1'b0;

    // L=3, P=0, up, one-shot; start in IDLE is ignored
    add(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; cfg_valid = tbl[i].cv; cfg_limit = tbl[i].l; cfg_presc = tbl[i].p;
      cfg_periodic = tbl[i].per; cfg_down = tbl[i].dn; start = tbl[i].st; stop = tbl[i].sp;
      evt_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d count", i), 32'(count),     32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d busy", i),  32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("vec%0d evt", i),   32'(evt_valid), 32'(tbl[i].e_evt));
      chk($sformatf("vec%0d miss", i),  32'(evt_miss),  32'(tbl[i].e_miss));
      chk($sformatf("vec%0d ready", i), 32'(cfg_ready), 32'(tbl[i].e_rdy));
    end
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; evt_ready = 1'b0;

    // periodic down, L=2 P=1, consumer always ready
    do_cfg(16'd2, 8'd1, 1'b1, 1'b1);
    evt_ready = 1'b1;
    start = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      tick();
      start = 1'b0;
      chk($sformatf("per_dn count S+%0d", j), 32'(count), 32'(seq[(j-1)%6]));
      chk($sformatf("per_dn evt S+%0d", j), 32'(evt_valid), 32'((j > 1) && ((j-1) % 6 == 0)));
      chk($sformatf("per_dn miss S+%0d", j), 32'(evt_miss), 32'(0));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    evt_ready = 1'b0;

    // L=0 P=0 periodic with a stalled consumer: every tick is terminal
    do_cfg(16'd0, 8'd0, 1'b1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("l0 evt S+1", 32'(evt_valid), 32'(0));
    tick();
    chk("l0 evt S+2", 32'(evt_valid), 32'(1));
    chk("l0 miss S+2", 32'(evt_miss), 32'(0));
    tick();
    chk("l0 miss S+3", 32'(evt_miss), 32'(1));
    tick(); tick();
    chk("l0 miss sticky", 32'(evt_miss), 32'(1));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("l0 stop busy", 32'(busy), 32'(0));
    chk("l0 stop keeps evt", 32'(evt_valid), 32'(1));
    do_cfg(16'd0, 8'd0, 1'b1, 1'b0);
    chk("l0 cfg clears miss", 32'(evt_miss), 32'(0));
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("l0 evt consumed", 32'(evt_valid), 32'(0));

    // stop and start together on the 3rd run cycle, then full restart
    do_cfg(16'd5, 8'd0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("stop pre count", 32'(count), 32'(2));
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("stop busy", 32'(busy), 32'(0));
    chk("stop count frozen", 32'(count), 32'(2));
    tick(); tick();
    chk("stop hold count", 32'(count), 32'(2));
    chk("stop no evt", 32'(evt_valid), 32'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("restart count", 32'(count), 32'(0));
    for (int j = 2; j <= 6; j++) tick();
    chk("restart evt S+6", 32'(evt_valid), 32'(0));
    tick();
    chk("restart evt S+7", 32'(evt_valid), 32'(1));
    chk("restart count hold", 32'(count), 32'(5));
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // cfg during run is refused; reset mid-run drops everything
    do_cfg(16'd4, 8'd0, 1'b1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_limit = 16'd1; cfg_down = 1'b1;
    #1;
    chk("run cfg_ready", 32'(cfg_ready), 32'(0));
    tick(); cfg_valid = 1'b0; cfg_down = 1'b0;
    chk("run cfg ignored", 32'(count), 32'(2));
    tick(); tick(); tick();
    chk("run evt", 32'(evt_valid), 32'(1));
    chk("run wrap count", 32'(count), 32'(0));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst count", 32'(count), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst evt", 32'(evt_valid), 32'(0));
    chk("rst miss", 32'(evt_miss), 32'(0));
    chk("rst ready", 32'(cfg_ready), 32'(1));
    start = 1'b1; tick(); tick(); tick(); start = 1'b0;
    chk("idle start ignored", 32'(busy), 32'(0));

    // maximum values on the 4-bit instance
    tick(); w_rst = 1'b0;
    w_cfg_valid = 1'b1; w_limit = 4'd15; w_presc = 8'd255; w_periodic = 1'b0; w_down = 1'b0;
    tick(); w_cfg_valid = 1'b0;
    w_start = 1'b1; tick(); w_start = 1'b0;
    chk("max busy S+1", 32'(w_busy), 32'(1));
    for (int j = 2; j <= 4096; j++) tick();
    chk("max evt S+4096", 32'(w_evt_valid), 32'(0));
    chk("max count S+4096", 32'(w_count), 32'(15));
    tick();
    chk("max evt S+4097", 32'(w_evt_valid), 32'(1));
    chk("max busy S+4097", 32'(w_busy), 32'(0));
    chk("max count hold", 32'(w_count), 32'(15));

    // randomized traffic; every cycle compared inside tick()
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      cfg_valid    = ($urandom_range(0, 7) == 0);
      cfg_limit    = 16'($urandom_range(0, 5));
      cfg_presc    = 8'($urandom_range(0, 3));
      cfg_periodic = 1'($urandom_range(0, 1));
      cfg_down     = 1'($urandom_range(0, 1));
      start        = ($urandom_range(0, 3) == 0);
      stop         = ($urandom_range(0, 15) == 0);
      evt_ready    = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
